// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions: widths, EX/MEM control bundle,
// and the ALU control opcodes used by every stage.
package legv8_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic branch;
        logic uncond;
        logic cbnz;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } ex_mem_ctrl_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_PIB = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/legv8_perf_counter.sv
// Wrapping event counter with async active-low clear.
module legv8_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/legv8_ex_mem_stage.sv
// EX/MEM pipeline register with MEM-stage branch resolution,
// one-shot redirect/flush and retire/taken performance counters.
module legv8_ex_mem_stage
    import legv8_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_pc,
    input  logic [DATA_W-1:0]     ex_imm,
    input  logic [DATA_W-1:0]     ALU_result,
    input  logic                  zero,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch,
    input  logic                  ex_uncond,
    input  logic                  ex_cbnz,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  mem_stall,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_alu_result,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_reg_write,
    output logic                  mem_mem_to_reg,
    output logic [DATA_W-1:0]     branch_target,
    output logic                  redirect,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      taken_cnt
);

    ex_mem_ctrl_t          ctrl_d;
    ex_mem_ctrl_t          ctrl_q;
    logic                  valid_q;
    logic                  taken_q;
    logic                  redirect_done;
    logic [DATA_W-1:0]     alu_q;
    logic [DATA_W-1:0]     store_q;
    logic [DATA_W-1:0]     target_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  taken_d;
    logic [DATA_W-1:0]     target_d;

    assign ctrl_d = '{
        branch:     ex_branch,
        uncond:     ex_uncond,
        cbnz:       ex_cbnz,
        mem_read:   ex_mem_read,
        mem_write:  ex_mem_write,
        reg_write:  ex_reg_write,
        mem_to_reg: ex_mem_to_reg
    };

    // CBZ taken on zero, CBNZ on non-zero; B always wins.
    assign taken_d  = ex_uncond | (ex_branch & (zero ^ ex_cbnz));
    assign target_d = ex_pc + (ex_imm << 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            alu_q    <= '0;
            store_q  <= '0;
            target_q <= '0;
            rd_q     <= '0;
            ctrl_q   <= '0;
        end else if (!mem_stall) begin
            valid_q  <= ex_valid & ~redirect;
            taken_q  <= taken_d;
            alu_q    <= ALU_result;
            store_q  <= ex_store_data;
            target_q <= target_d;
            rd_q     <= ex_rd;
            ctrl_q   <= ctrl_d;
        end
    end

    // Remembers that a stalled taken branch already redirected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_done <= 1'b0;
        end else if (!mem_stall) begin
            redirect_done <= 1'b0;
        end else if (redirect) begin
            redirect_done <= 1'b1;
        end
    end

    assign redirect = valid_q & taken_q & ~redirect_done;

    assign mem_valid      = valid_q;
    assign mem_alu_result = alu_q;
    assign mem_store_data = store_q;
    assign mem_rd         = rd_q;
    assign branch_target  = target_q;
    assign mem_mem_read   = valid_q & ctrl_q.mem_read;
    assign mem_mem_write  = valid_q & ctrl_q.mem_write;
    assign mem_reg_write  = valid_q & ctrl_q.reg_write;
    assign mem_mem_to_reg = valid_q & ctrl_q.mem_to_reg;

    legv8_perf_counter #(.CNT_W(CNT_W)) u_retired (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (valid_q & ~mem_stall),
        .count (retired_cnt)
    );

    legv8_perf_counter #(.CNT_W(CNT_W)) u_taken (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (redirect),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_legv8_ex_mem_stage.sv
// Directed vector bench for legv8_ex_mem_stage: table-driven captures
// plus squash, stall-redirect and async-reset sequences.
module tb_legv8_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic [63:0] ex_pc;
    logic [63:0] ex_imm;
    logic [63:0] ALU_result;
    logic        zero;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_branch;
    logic        ex_uncond;
    logic        ex_cbnz;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        mem_stall;
    logic        mem_valid;
    logic [63:0] mem_alu_result;
    logic [63:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_reg_write;
    logic        mem_mem_to_reg;
    logic [63:0] branch_target;
    logic        redirect;
    logic [31:0] retired_cnt;
    logic [31:0] taken_cnt;

    legv8_ex_mem_stage #(
        .DATA_W(64), .REG_ADDR_W(5), .CNT_W(32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ALU_result     (ALU_result),
        .zero           (zero),
        .ex_store_data  (ex_store_data),
        .ex_rd          (ex_rd),
        .ex_branch      (ex_branch),
        .ex_uncond      (ex_uncond),
        .ex_cbnz        (ex_cbnz),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .mem_stall      (mem_stall),
        .mem_valid      (mem_valid),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_to_reg (mem_mem_to_reg),
        .branch_target  (branch_target),
        .redirect       (redirect),
        .retired_cnt    (retired_cnt),
        .taken_cnt      (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] alu;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        zero;
        logic        br;
        logic        un;
        logic        cbnz;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
        logic        e_valid;
        logic [63:0] e_tgt;
        logic        e_redir;
        logic        e_mr;
        logic        e_mw;
        logic        e_rw;
        logic        e_m2r;
    } vec_t;

    vec_t vecs [10];
    int   n_cmp;
    int   n_fail;
    int   exp_ret;
    int   exp_tak;
    int   pulses;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        ex_valid      = v.valid;
        ex_pc         = v.pc;
        ex_imm        = v.imm;
        ALU_result    = v.alu;
        ex_store_data = v.sd;
        ex_rd         = v.rd;
        zero          = v.zero;
        ex_branch     = v.br;
        ex_uncond     = v.un;
        ex_cbnz       = v.cbnz;
        ex_mem_read   = v.mr;
        ex_mem_write  = v.mw;
        ex_reg_write  = v.rw;
        ex_mem_to_reg = v.m2r;
    endtask

    task automatic idle();
        ex_valid      = 1'b0;
        ex_pc         = '0;
        ex_imm        = '0;
        ALU_result    = '0;
        ex_store_data = '0;
        ex_rd         = '0;
        zero          = 1'b0;
        ex_branch     = 1'b0;
        ex_uncond     = 1'b0;
        ex_cbnz       = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
    endtask

    initial begin
        vec_t v;
        n_cmp   = 0;
        n_fail  = 0;
        exp_ret = 0;
        exp_tak = 0;
        mem_stall = 1'b0;
        idle();

        // valid pc imm alu sd rd zero br un cbnz mr mw rw m2r |
        // e_valid e_tgt e_redir e_mr e_mw e_rw e_m2r
        vecs[0] = '{1, 64'h1000, 64'd4, 64'h0, 64'h0, 5'd0,
                    1, 1, 0, 0, 0, 0, 0, 0,
                    1, 64'h1010, 1, 0, 0, 0, 0};
        vecs[1] = '{1, 64'h2000, 64'd1, 64'h5, 64'h0, 5'd0,
                    1, 1, 0, 1, 0, 0, 0, 0,
                    1, 64'h2004, 0, 0, 0, 0, 0};
        vecs[2] = '{1, 64'h4, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0,
                    64'h0, 5'd0,
                    0, 0, 1, 0, 0, 0, 0, 0,
                    1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 0};
        vecs[3] = '{0, 64'h10, 64'd0, 64'h33, 64'h0, 5'd2,
                    0, 0, 0, 0, 0, 1, 1, 0,
                    0, 64'h10, 0, 0, 0, 0, 0};
        vecs[4] = '{1, 64'h20, 64'd0, 64'h80, 64'hDEAD, 5'd3,
                    0, 0, 0, 0, 0, 1, 0, 0,
                    1, 64'h20, 0, 0, 1, 0, 0};
        vecs[5] = '{1, 64'h24, 64'd0, 64'h88, 64'h0, 5'd9,
                    0, 0, 0, 0, 1, 0, 1, 1,
                    1, 64'h24, 0, 1, 0, 1, 1};
        vecs[6] = '{1, 64'h100, 64'd3, 64'h0, 64'h0, 5'd0,
                    0, 1, 0, 1, 0, 0, 0, 0,
                    1, 64'h10C, 1, 0, 0, 0, 0};
        vecs[7] = '{1, 64'h200, 64'd8, 64'h0, 64'h0, 5'd0,
                    0, 1, 0, 0, 0, 0, 0, 0,
                    1, 64'h220, 0, 0, 0, 0, 0};
        vecs[8] = '{1, 64'h300, 64'h10, 64'h0, 64'h0, 5'd0,
                    0, 1, 1, 0, 0, 0, 0, 0,
                    1, 64'h340, 1, 0, 0, 0, 0};
        vecs[9] = '{1, 64'h400, 64'd2, 64'h7, 64'h0, 5'd1,
                    1, 0, 0, 0, 0, 0, 1, 0,
                    1, 64'h408, 0, 0, 0, 1, 0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_redirect", 64'(redirect), 64'd0);
        chk("rst_target", branch_target, 64'd0);
        chk("rst_retired", 64'(retired_cnt), 64'd0);
        chk("rst_taken", 64'(taken_cnt), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 64'(mem_valid),
                64'(vecs[i].e_valid));
            chk($sformatf("v%0d_target", i), branch_target,
                vecs[i].e_tgt);
            chk($sformatf("v%0d_redirect", i), 64'(redirect),
                64'(vecs[i].e_redir));
            chk($sformatf("v%0d_mem_read", i), 64'(mem_mem_read),
                64'(vecs[i].e_mr));
            chk($sformatf("v%0d_mem_write", i), 64'(mem_mem_write),
                64'(vecs[i].e_mw));
            chk($sformatf("v%0d_reg_write", i), 64'(mem_reg_write),
                64'(vecs[i].e_rw));
            chk($sformatf("v%0d_mem_to_reg", i), 64'(mem_mem_to_reg),
                64'(vecs[i].e_m2r));
            chk($sformatf("v%0d_alu", i), mem_alu_result, vecs[i].alu);
            chk($sformatf("v%0d_store", i), mem_store_data, vecs[i].sd);
            chk($sformatf("v%0d_rd", i), 64'(mem_rd), 64'(vecs[i].rd));
            idle();
            @(negedge clk);
            if (vecs[i].e_valid) exp_ret++;
            if (vecs[i].e_redir) exp_tak++;
            chk($sformatf("v%0d_retired", i), 64'(retired_cnt),
                64'(exp_ret));
            chk($sformatf("v%0d_taken", i), 64'(taken_cnt),
                64'(exp_tak));
        end

        // Younger instruction in EX during a redirect is squashed.
        v = vecs[0];
        v.pc = 64'h500;
        v.imm = 64'd1;
        apply(v);
        @(negedge clk);
        chk("sq_redirect", 64'(redirect), 64'd1);
        chk("sq_target", branch_target, 64'h504);
        idle();
        ex_valid = 1'b1;
        ex_reg_write = 1'b1;
        ALU_result = 64'h77;
        ex_rd = 5'd4;
        @(negedge clk);
        exp_ret++;
        exp_tak++;
        chk("sq_valid", 64'(mem_valid), 64'd0);
        chk("sq_reg_write", 64'(mem_reg_write), 64'd0);
        chk("sq_retired", 64'(retired_cnt), 64'(exp_ret));
        chk("sq_taken", 64'(taken_cnt), 64'(exp_tak));
        idle();
        @(negedge clk);
        chk("sq_bubble_ret", 64'(retired_cnt), 64'(exp_ret));

        // Taken B held in MEM by a 3-cycle stall.
        v = vecs[2];
        v.pc = 64'h600;
        v.imm = 64'd4;
        v.alu = 64'hAB;
        apply(v);
        @(negedge clk);
        pulses = 0;
        if (redirect) pulses++;
        chk("st_target", branch_target, 64'h610);
        mem_stall = 1'b1;
        idle();
        ex_valid = 1'b1;
        ex_reg_write = 1'b1;
        ALU_result = 64'hCD;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (redirect) pulses++;
            chk($sformatf("st%0d_alu_held", c), mem_alu_result,
                64'hAB);
            chk($sformatf("st%0d_valid", c), 64'(mem_valid), 64'd1);
        end
        exp_tak++;
        chk("st_taken", 64'(taken_cnt), 64'(exp_tak));
        chk("st_retired_held", 64'(retired_cnt), 64'(exp_ret));
        mem_stall = 1'b0;
        @(negedge clk);
        exp_ret++;
        chk("st_pulses", 64'(pulses), 64'd1);
        chk("st_rel_retired", 64'(retired_cnt), 64'(exp_ret));
        chk("st_rel_taken", 64'(taken_cnt), 64'(exp_tak));
        chk("st_rel_alu", mem_alu_result, 64'hCD);
        chk("st_rel_valid", 64'(mem_valid), 64'd1);
        chk("st_rel_redirect", 64'(redirect), 64'd0);
        idle();
        @(negedge clk);
        exp_ret++;
        chk("st_young_ret", 64'(retired_cnt), 64'(exp_ret));

        // Async reset while a redirect is pending.
        v = vecs[2];
        v.pc = 64'h700;
        v.imm = 64'd1;
        v.alu = 64'h55;
        apply(v);
        @(negedge clk);
        chk("ar_pre_redirect", 64'(redirect), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(mem_valid), 64'd0);
        chk("ar_redirect", 64'(redirect), 64'd0);
        chk("ar_target", branch_target, 64'd0);
        chk("ar_alu", mem_alu_result, 64'd0);
        chk("ar_retired", 64'(retired_cnt), 64'd0);
        chk("ar_taken", 64'(taken_cnt), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_ex_mem_stage.md
Name: legv8_ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the LEGv8 ALU. It captures `ALU_result`, `zero` and the EX-stage control and operands at each advance.
- It resolves CBZ/CBNZ/B in the MEM stage and issues the PC redirect plus a one-shot flush of the younger pipeline stages.
- It holds two performance counters: retired MEM-stage instructions and taken branches.

Parameters:
- DATA_W, 64, datapath width (PC, ALU result, store data).
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a live instruction.
- ex_pc  in  DATA_W  PC of the EX instruction.
- ex_imm  in  DATA_W  sign-extended branch offset, in words.
- ALU_result  in  DATA_W  ALU output.
- zero  in  1  ALU zero flag.
- ex_store_data  in  DATA_W  Rt value for STUR.
- ex_rd  in  REG_ADDR_W  destination register.
- ex_branch, ex_uncond, ex_cbnz  in  1 each  conditional branch, B, CBNZ select.
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  in  1 each  control bits passed through.
- mem_stall  in  1  data memory not ready; hold the stage.
- mem_valid  out  1  MEM holds a live instruction.
- mem_alu_result, mem_store_data  out  DATA_W  registered copies.
- mem_rd  out  REG_ADDR_W  registered destination register.
- mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg  out  1 each  registered control, each gated by mem_valid.
- branch_target  out  DATA_W  registered redirect PC.
- redirect  out  1  take branch_target this cycle; flush IF/ID and ID/EX.
- retired_cnt, taken_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset (async, rst_n=0): every output register is 0, the internal redirect_done flag is 0, and redirect=0.
- Advance: on a clk edge with mem_stall=0, every stage register loads from the EX inputs. Latency is 1 cycle.
- Stall: on a clk edge with mem_stall=1, every stage register holds its value.
- Captured valid: mem_valid loads ex_valid & ~redirect. The instruction in EX during a redirect is squashed.
- Branch target: the registered value is ex_pc + (ex_imm << 2), computed mod 2^DATA_W; wrap-around is allowed.
- Taken condition, registered as taken_q: ex_uncond | (ex_branch & (zero ^ ex_cbnz)).
  - CBZ is taken when zero=1.
  - CBNZ is taken when zero=0.
  - If ex_uncond and ex_branch are both 1, ex_uncond wins.
- Redirect: redirect = mem_valid & taken_q & ~redirect_done, combinational from registered state.
- redirect_done:
  - Set on any edge where redirect=1 and mem_stall=1.
  - Cleared on any edge where mem_stall=0.
  - Effect: a taken branch that sits in MEM under stall pulses redirect exactly once, in its first MEM cycle.
- Stores and loads are never squashed by their own redirect; the redirect only affects younger instructions.
- mem_* control outputs are forced to 0 when mem_valid=0, so a bubble can never write memory or registers.
- retired_cnt: increments by 1 on each advancing edge where mem_valid=1.
- taken_cnt: increments by 1 on each cycle where redirect=1.
- Both counters wrap modulo 2^CNT_W.
- Reset mid-operation clears everything immediately, including a pending redirect. There is no output glitch requirement beyond the async clear.

Decomposition:
- Shared package `legv8_pkg`:
  - DATA_W and REG_ADDR_W constants.
  - A packed struct `ex_mem_ctrl_t` with fields branch, uncond, cbnz, mem_read, mem_write, reg_write, mem_to_reg.
  - The ALU control opcode constants (AND, OR, ADD, SUB, PIB, NOR), so all stages share one definition.
- One sub-module is natural: `legv8_perf_counter`, instantiated twice. Ports: clk, rst_n, inc, count[CNT_W].
- The branch resolve logic stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with mem_valid=1 and redirect=1 -> all outputs read 0 immediately, with no clock edge needed.
- CBZ taken: ex_pc=0x1000, ex_imm=4, ex_branch=1, zero=1, advance -> next cycle mem_valid=1, branch_target=0x1010, redirect=1, and taken_cnt goes 0→1 at the following edge. The instruction in EX during the redirect has mem_valid=0 after the next edge.
- CBNZ not taken: ex_branch=1, ex_cbnz=1, zero=1 -> redirect stays 0 and retired_cnt increments by 1.
- Backward B with wrap: ex_pc=0x4, ex_imm=−2 (0xFFFF_FFFF_FFFF_FFFE), ex_uncond=1 -> branch_target=0xFFFF_FFFF_FFFF_FFFC and redirect=1.
- Stall during taken branch: mem_stall=1 for 3 cycles while a taken B is in MEM -> redirect high for exactly 1 cycle, registers held, taken_cnt +1 only, retired_cnt +1 only when the stall releases.
- Bubble gating: ex_valid=0 with ex_mem_write=1, ex_reg_write=1 -> mem_mem_write=0, mem_reg_write=0, and retired_cnt unchanged.
